// File: rtl/fetch_seq_if.sv
// ---------------------------------------------------------------------------
// fetch_seq_if: bus between the fetch sequencer and its neighbours.
//   ROM side     : rom_addr (seq -> ROM), rom_data (ROM -> seq, same cycle)
//   Execute side : ir, ir_valid (seq -> ex); ex_done, br_take, br_addr
//                  (ex -> seq)
// The master modport is the sequencer. The slave modport is the ROM/execute
// side, or a testbench standing in for both.
// ---------------------------------------------------------------------------
interface fetch_seq_if;
  logic [7:0]  rom_addr;
  logic [12:0] rom_data;
  logic [12:0] ir;
  logic        ir_valid;
  logic        ex_done;
  logic        br_take;
  logic [7:0]  br_addr;

  modport master (
    output rom_addr, ir, ir_valid,
    input  rom_data, ex_done, br_take, br_addr
  );

  modport slave (
    input  rom_addr, ir, ir_valid,
    output rom_data, ex_done, br_take, br_addr
  );
endinterface

// File: rtl/fetch_seq.sv
// ---------------------------------------------------------------------------
// fetch_seq: instruction fetch sequencer.
// This block owns the PC and addresses a combinational 13-bit ROM. It latches
// each word into the IR and presents it to execute with a one-cycle ir_valid
// pulse. It then waits for ex_done, and on ex_done it either increments the
// PC or takes the branch. It stops at HALT_OP and can pause after every
// instruction for single-step operation.
// Ports:
//   clk, rst      : clock, async active-high reset
//   bus           : fetch_seq_if.master (ROM + execute handshake)
//   start_i       : run request (IDLE / PAUSE / HALT)
//   step_en_i     : pause after each retired instruction
//   pc_o          : program counter
//   halted_o      : high while halted
//   retired_o     : retired instruction count, saturating
// ---------------------------------------------------------------------------
module fetch_seq #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [4:0] HALT_OP  = 5'h1F
) (
  input  logic          clk,
  input  logic          rst,
  fetch_seq_if.master   bus,
  input  logic          start_i,
  input  logic          step_en_i,
  output logic [7:0]    pc_o,
  output logic          halted_o,
  output logic [15:0]   retired_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_PAUSE, S_HALT
  } state_e;

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [12:0] ir_q;
  logic        ir_valid_q;
  logic        halted_q;
  logic [15:0] retired_q;

  // Next-value helpers used on WAIT exit
  logic [7:0]  pc_d;
  logic [15:0] retired_d;

  always_comb begin
    // An 8-bit add wraps FF to 00 by itself
    pc_d      = bus.br_take ? bus.br_addr : pc_q + 8'd1;
    retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 13'h0000;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= 16'h0000;
    end else begin
      // ir_valid is a single-cycle pulse; only FETCH re-arms it
      ir_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) state_q <= S_FETCH;
        end
        S_FETCH: begin
          ir_q       <= bus.rom_data;
          ir_valid_q <= 1'b1;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          // Halt is decided from the latched IR, so no handshake is made
          // and the PC stays on the halt word
          if (ir_q[12:8] == HALT_OP) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.ex_done) begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
            state_q   <= step_en_i ? S_PAUSE : S_FETCH;
          end
        end
        S_PAUSE: begin
          if (start_i) state_q <= S_FETCH;
        end
        S_HALT: begin
          if (start_i) begin
            pc_q      <= RESET_PC;
            retired_q <= 16'h0000;
            halted_q  <= 1'b0;
            state_q   <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign pc_o         = pc_q;
  assign halted_o     = halted_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, step_en;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired;

  fetch_seq_if ifc ();

  fetch_seq dut (
    .clk(clk), .rst(rst), .bus(ifc.master),
    .start_i(start), .step_en_i(step_en),
    .pc_o(pc), .halted_o(halted), .retired_o(retired)
  );

  always #5 clk = ~clk;

  // Combinational ROM model
  logic [12:0] rom [256];
  assign ifc.rom_data = rom[ifc.rom_addr];

  typedef struct packed { logic [12:0] ir; logic [7:0] pc; } exp_t;
  exp_t exp_q [$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, iv_count = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ir_valid pulse must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && ifc.ir_valid) begin
      iv_count++;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_ir_valid: got ir=%0h pc=%0h, expected no issue", ifc.ir, pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_ir", {19'd0, ifc.ir}, {19'd0, e.ir});
        chk("issue_pc", {24'd0, pc}, {24'd0, e.pc});
      end
    end
  end

  task automatic wait_iv();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.ir_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL wait_ir_valid: got timeout, expected pulse");
    end
  endtask

  // Execute responds in the first WAIT cycle
  task automatic exec(input logic br, input logic [7:0] addr);
    @(negedge clk);
    ifc.ex_done = 1'b1; ifc.br_take = br; ifc.br_addr = addr;
    @(negedge clk);
    ifc.ex_done = 1'b0; ifc.br_take = 1'b0; ifc.br_addr = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, c0;
    for (int i = 0; i < 256; i++) rom[i] = 13'h1000;
    rom[8'h00] = 13'h1D00; rom[8'h01] = 13'h1200; rom[8'h02] = 13'h1100;
    rom[8'h03] = 13'h1000; rom[8'h12] = 13'h1506; rom[8'h06] = 13'h1000;
    rom[8'h15] = 13'h1F00; rom[8'hFF] = 13'h1000; rom[8'h30] = 13'h0102;

    start = 0; step_en = 0;
    ifc.ex_done = 0; ifc.br_take = 0; ifc.br_addr = 8'h00;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_rom_addr", {24'd0, ifc.rom_addr}, 32'h00);
    chk("rst_ir", {19'd0, ifc.ir}, 32'h0000);
    chk("rst_ir_valid", {31'd0, ifc.ir_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);

    // First fetch: ir_valid lands two cycles after start
    exp_q.push_back('{13'h1D00, 8'h00});
    pulse_start();
    chk("fetch_no_iv", {31'd0, ifc.ir_valid}, 32'd0);
    @(negedge clk);
    chk("first_iv", {31'd0, ifc.ir_valid}, 32'd1);
    chk("first_ir", {19'd0, ifc.ir}, 32'h1D00);
    t0 = cyc;
    @(negedge clk);
    chk("iv_single_cycle", {31'd0, ifc.ir_valid}, 32'd0);
    ifc.ex_done = 1'b1;
    @(negedge clk);
    ifc.ex_done = 1'b0;

    // Sequential run at the minimum 3-cycle period
    exp_q.push_back('{13'h1200, 8'h01});
    wait_iv();
    chk("period_1", cyc - t0, 32'd3);
    t0 = cyc;
    exec(1'b0, 8'h00);
    exp_q.push_back('{13'h1100, 8'h02});
    wait_iv();
    chk("period_2", cyc - t0, 32'd3);
    exec(1'b0, 8'h00);
    chk("seq_pc", {24'd0, pc}, 32'h03);
    chk("seq_retired", {16'd0, retired}, 32'd3);

    // Branch to 0x12, then from 0x12 to 0x06
    exp_q.push_back('{13'h1000, 8'h03});
    wait_iv();
    exec(1'b1, 8'h12);
    exp_q.push_back('{13'h1506, 8'h12});
    wait_iv();
    r0 = retired;
    exec(1'b1, 8'h06);
    chk("br_rom_addr", {24'd0, ifc.rom_addr}, 32'h06);
    chk("br_retired", {16'd0, retired}, r0 + 1);
    exp_q.push_back('{13'h1000, 8'h06});
    wait_iv();
    exec(1'b1, 8'h15);

    // Halt
    exp_q.push_back('{13'h1F00, 8'h15});
    wait_iv();
    @(negedge clk);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    c0 = iv_count;
    for (int i = 0; i < 6; i++) begin
      ifc.ex_done = i[0];
      @(negedge clk);
    end
    ifc.ex_done = 0;
    chk("halt_no_iv", iv_count, c0);
    chk("halt_pc", {24'd0, pc}, 32'h15);
    chk("halt_retired", {16'd0, retired}, 32'd6);

    // Restart from HALT
    exp_q.push_back('{13'h1D00, 8'h00});
    pulse_start();
    chk("restart_halted", {31'd0, halted}, 32'd0);
    chk("restart_pc", {24'd0, pc}, 32'h00);
    chk("restart_retired", {16'd0, retired}, 32'd0);
    wait_iv();

    // Wrap FF->00 under single-step
    exec(1'b1, 8'hFF);
    exp_q.push_back('{13'h1000, 8'hFF});
    wait_iv();
    step_en = 1;
    exec(1'b0, 8'h00);
    chk("wrap_pc", {24'd0, pc}, 32'h00);
    c0 = iv_count;
    repeat (5) @(negedge clk);
    chk("pause_no_iv", iv_count, c0);
    chk("pause_retired", {16'd0, retired}, 32'd2);
    step_en = 0;
    exp_q.push_back('{13'h1D00, 8'h00});
    pulse_start();
    wait_iv();

    // Async reset in the middle of WAIT
    exec(1'b1, 8'h30);
    exp_q.push_back('{13'h0102, 8'h30});
    wait_iv();
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_pc", {24'd0, pc}, 32'h00);
    chk("arst_ir", {19'd0, ifc.ir}, 32'h0000);
    chk("arst_retired", {16'd0, retired}, 32'd0);
    @(negedge clk);
    rst = 0;
    c0 = iv_count;
    exec(1'b1, 8'h40);
    repeat (4) @(negedge clk);
    chk("arst_no_iv", iv_count, c0);
    chk("arst_exdone_ignored_pc", {24'd0, pc}, 32'h00);
    chk("arst_exdone_ignored_ret", {16'd0, retired}, 32'd0);
    exp_q.push_back('{13'h1D00, 8'h00});
    pulse_start();
    wait_iv();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch sequencer for the very simple processor. It owns the program counter and drives the address of the 13-bit combinational instruction ROM. It latches each fetched word into an instruction register and hands it to the execute stage with a valid/done handshake. It applies branch redirects from execute, recognises the halt opcode, and supports single-step operation.

## Interface
- `RESET_PC`, 8'h00: PC value loaded on reset and on restart from HALT.
- `HALT_OP`, 5'h1F: opcode (`ir[12:8]`) that stops fetching.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled run request, honoured in IDLE, PAUSE and HALT.
- `step_en`  in  1  single-step mode. When 1, the sequencer pauses after every retired instruction.
- `rom_addr`  out  8  ROM address. Combinationally equal to `pc`.
- `rom_data`  in  13  ROM instruction word, valid in the same cycle as `rom_addr`.
- `ir`  out  13  instruction register. `[12:8]` is the opcode, `[7:0]` is the operand.
- `ir_valid`  out  1  one-cycle pulse: `ir` holds a new instruction for execute.
- `ex_done`  in  1  execute has finished the current instruction. Sampled only in WAIT.
- `br_take`  in  1  qualifies `ex_done`: load `br_addr` instead of incrementing the PC.
- `br_addr`  in  8  branch target.
- `pc`  out  8  program counter.
- `halted`  out  1  high while in HALT.
- `retired`  out  16  count of instructions completed via `ex_done`, saturating at 16'hFFFF.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, PAUSE, HALT. Encoding is free.
- Reset (asynchronous) forces:
  - state IDLE, `pc`=RESET_PC, `ir`=13'h0000
  - `ir_valid`=0, `halted`=0, `retired`=0
- IDLE: `start`=1 moves to FETCH. Otherwise stay.
- FETCH: `ir` <= `rom_data` (the word at `pc`). Move to ISSUE.
- ISSUE: `ir_valid`=1 for exactly this cycle.
  - If `ir[12:8]`==HALT_OP, move to HALT. No handshake takes place, `pc` is unchanged and `retired` is not incremented.
  - Otherwise move to WAIT.
- WAIT: hold until `ex_done`=1. On `ex_done`:
  - `pc` <= `br_take` ? `br_addr` : `pc`+1. The increment is 8-bit and wraps 8'hFF to 8'h00.
  - `retired` increments by 1, saturating.
  - Next state is PAUSE if `step_en`=1, else FETCH.
- PAUSE: `start`=1 moves to FETCH, which fetches at the already-updated `pc`.
- HALT: `halted`=1. `start`=1 sets `pc` <= RESET_PC, clears `retired` and moves to FETCH. `halted` falls with the state change.
- Ignored inputs:
  - `ex_done`, `br_take` and `br_addr` outside WAIT.
  - `start` in FETCH, ISSUE and WAIT.
- `step_en` is sampled only at the WAIT exit. Changing it mid-instruction has no other effect.
- `ir` holds its value between fetches. Execute may read it at any time after `ir_valid`.

## Timing
- `start` sampled at edge k: FETCH during cycle k→k+1, `ir` loaded at edge k+1, `ir_valid` high cycle k+1→k+2, WAIT from edge k+2.
- `ex_done` sampled at edge m: new `pc` visible after edge m. In free-run, FETCH is cycle m→m+1.
- Minimum instruction period is 3 cycles (FETCH, ISSUE, WAIT with `ex_done` in its first cycle).
- `ex_done` held high for several cycles retires one instruction only. Leaving WAIT drops the sample, and the next WAIT starts at least 2 cycles later.
- `rst` asserted in any state, including mid-WAIT, takes effect immediately, with no clock needed. On release, the first edge sees IDLE and an in-flight instruction is discarded.
- `ir_valid` is never high for two consecutive cycles.

## Test plan
- Reset and first fetch: assert `rst`, then release. Required: `pc`=8'h00, `rom_addr`=8'h00, `ir_valid`=0, `halted`=0, `retired`=0. Then `start` with `rom_data`=13'h1D00 → `ir`=13'h1D00 with `ir_valid` pulsing once, 2 cycles after `start`.
- Sequential run: words 13'h1D00, 13'h1200, 13'h1100 at 0..2, `ex_done` 1 cycle after each `ir_valid`, `br_take`=0. Required: `pc` goes 0→1→2→3, each instruction takes 3 cycles, `retired`=3.
- Branch: `ir`=13'h1506 at `pc`=8'h12, then `ex_done`=1, `br_take`=1, `br_addr`=8'h06. Required: next `rom_addr`=8'h06, next `ir`=13'h1000, `retired` increments by 1.
- Halt: `rom_data`=13'h1F00 at `pc`=8'h15. Required: `ir_valid` pulses once, `halted`=1, `pc` stays 8'h15, no further `ir_valid` while `ex_done` is toggled. Then `start` → `pc`=8'h00, `retired`=0, fetch resumes.
- Wrap and step: set `pc`=8'hFF via a branch, `step_en`=1, `ex_done` with `br_take`=0. Required: `pc`=8'h00, state PAUSE, no `ir_valid` until `start`. Then `start` → fetch at 8'h00.
- Asynchronous reset mid-WAIT: after `ir`=13'h0102 is issued, assert `rst` between clock edges. Required: `pc`, `ir` and `retired` clear immediately. A later `ex_done` is ignored, and `ir_valid` stays 0 until the next `start`.
